// File: rtl/winograd_output_transform.sv
// Winograd F(2x2,3x3) output transform: sums NCH 4x4 product tiles per group, then
// emits Y = A^T S A as one 2x2 tile through a two-stage valid/ready pipeline.
module winograd_output_transform #(
    parameter int IW  = 16,
    parameter int AW  = 24,
    parameter int NCH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*IW-1:0]    in_tile,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*(AW+4)-1:0] out_tile
);

    localparam int OW = AW + 4;
    localparam int TW = AW + 2;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    logic [AW-1:0] acc    [16];
    logic [AW-1:0] sum    [16];
    logic [TW-1:0] t_nxt  [2][4];
    logic [TW-1:0] s1_t   [2][4];
    logic [OW-1:0] y_nxt  [4];
    logic [CW-1:0] ch_cnt;
    logic          s1_valid;
    logic          s1_free;
    logic          s2_free;
    logic          s2_load;
    logic          accept;
    logic          last;

    function automatic logic [AW-1:0] ext_a(input logic [IW-1:0] v);
        return {{(AW-IW){v[IW-1]}}, v};
    endfunction

    function automatic logic [TW-1:0] ext_t(input logic [AW-1:0] v);
        return {{(TW-AW){v[AW-1]}}, v};
    endfunction

    function automatic logic [OW-1:0] ext_o(input logic [TW-1:0] v);
        return {{(OW-TW){v[TW-1]}}, v};
    endfunction

    assign s2_free  = !out_valid || out_ready;
    assign s1_free  = !s1_valid || s2_free;
    assign in_ready = s1_free && !clr;
    assign accept   = in_valid && in_ready;
    assign last     = (ch_cnt == LAST_CH);
    assign s2_load  = s1_valid && s2_free;

    // Operands are sign-extended to the result width first, so plain two's-complement
    // adds give the signed result without relying on expression-context sizing.
    // NOTE: every loop below writes every element, so no element can hold its old value
    // and no latch is inferred.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sum[k] = acc[k] + ext_a(in_tile[k*IW +: IW]);
        end
        for (int c = 0; c < 4; c++) begin
            t_nxt[0][c] = ext_t(sum[c]) + ext_t(sum[4+c]) + ext_t(sum[8+c]);
            t_nxt[1][c] = ext_t(sum[4+c]) - ext_t(sum[8+c]) - ext_t(sum[12+c]);
        end
        for (int i = 0; i < 2; i++) begin
            y_nxt[2*i]   = ext_o(s1_t[i][0]) + ext_o(s1_t[i][1]) + ext_o(s1_t[i][2]);
            y_nxt[2*i+1] = ext_o(s1_t[i][1]) - ext_o(s1_t[i][2]) - ext_o(s1_t[i][3]);
        end
    end

    // NOTE: the accumulator array is architectural state that must start at zero for the
    // first group, so unlike plain pipeline data it is reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 16; k++) acc[k] <= '0;
            ch_cnt <= '0;
        end else if (clr) begin
            for (int k = 0; k < 16; k++) acc[k] <= '0;
            ch_cnt <= '0;
        end else if (accept) begin
            if (last) begin
                for (int k = 0; k < 16; k++) acc[k] <= '0;
                ch_cnt <= '0;
            end else begin
                for (int k = 0; k < 16; k++) acc[k] <= sum[k];
                ch_cnt <= ch_cnt + CW'(1);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values, which keeps the simultaneous load/drain cases well defined.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_tile  <= '0;
        end else if (clr) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept && last) s1_valid <= 1'b1;
            else if (s2_load)   s1_valid <= 1'b0;

            if (s2_load) begin
                out_valid <= 1'b1;
                for (int i = 0; i < 4; i++) out_tile[i*OW +: OW] <= y_nxt[i];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Stage-1 data is qualified by s1_valid and needs no reset.
    always_ff @(posedge clk) begin
        if (accept && last) s1_t <= t_nxt;
    end

endmodule

// File: tb/tb_winograd_output_transform.sv
// Directed and randomized checks for winograd_output_transform (IW=16, AW=24, NCH=4).
module tb_winograd_output_transform;

    localparam int IW  = 16;
    localparam int AW  = 24;
    localparam int NCH = 4;
    localparam int OW  = AW + 4;
    localparam int TB  = 16 * IW;
    localparam int YB  = 4 * OW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [TB-1:0] in_tile;
    logic          out_valid;
    logic          out_ready;
    logic [YB-1:0] out_tile;

    int checks   = 0;
    int failures = 0;

    winograd_output_transform #(.IW(IW), .AW(AW), .NCH(NCH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tile   (in_tile),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tile  (out_tile)
    );

    always #5 clk = ~clk;

    function automatic logic [TB-1:0] ramp_tile(input int mult);
        logic [TB-1:0] t;
        t = '0;
        for (int k = 0; k < 16; k++) t[k*IW +: IW] = 16'(mult * k);
        return t;
    endfunction

    function automatic logic [TB-1:0] rand_tile();
        logic [TB-1:0] t;
        for (int k = 0; k < TB / 32; k++) t[k*32 +: 32] = $urandom;
        return t;
    endfunction

    function automatic logic [YB-1:0] pack_y(input longint y00, input longint y01,
                                             input longint y10, input longint y11);
        logic [YB-1:0] p;
        p[0*OW +: OW] = 28'(y00);
        p[1*OW +: OW] = 28'(y01);
        p[2*OW +: OW] = 28'(y10);
        p[3*OW +: OW] = 28'(y11);
        return p;
    endfunction

    // One clock: drive on the falling edge, observe 1 ns later, return at the rising edge.
    task automatic tick(input logic v, input logic [TB-1:0] t, input logic r, input logic c,
                        output logic fi, output logic fo, output logic ov,
                        output logic [YB-1:0] y);
        @(negedge clk);
        in_valid  = v;
        in_tile   = t;
        out_ready = r;
        clr       = c;
        #1;
        fi = v && in_ready;
        ov = out_valid;
        fo = out_valid && r;
        y  = out_tile;
        @(posedge clk);
    endtask

    task automatic send_beat(input logic [TB-1:0] t, input int idle, input logic r,
                             output logic ok, output logic saw_ov);
        logic fi, fo, ov;
        logic [YB-1:0] y;
        ok = 1'b0;
        saw_ov = 1'b0;
        for (int i = 0; i < idle; i++) begin
            tick(1'b0, '0, r, 1'b0, fi, fo, ov, y);
            saw_ov |= ov;
        end
        for (int i = 0; i < 64 && !ok; i++) begin
            tick(1'b1, t, r, 1'b0, fi, fo, ov, y);
            saw_ov |= ov;
            ok = fi;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_tile = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_tile !== '0) begin
            failures++;
            $display("FAIL reset_out: out_valid=%b out_tile=%h, want 0/0", out_valid, out_tile);
        end
        rstn = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_ramp();
        logic ok, all_ok, saw, any_ov, fi, fo, ov;
        logic [YB-1:0] y;
        all_ok = 1'b1; any_ov = 1'b0;
        for (int b = 0; b < NCH; b++) begin
            send_beat(ramp_tile(1), 0, 1'b1, ok, saw);
            all_ok &= ok; any_ov |= saw;
        end
        checks++;
        if (!all_ok || any_ov) begin
            failures++;
            $display("FAIL ramp_accept: all_ok=%b early_out_valid=%b, want 1/0", all_ok, any_ov);
        end
        tick(1'b0, '0, 1'b1, 1'b0, fi, fo, ov, y);
        checks++;
        if (ov !== 1'b0) begin
            failures++;
            $display("FAIL ramp_latency_early: out_valid=%b want 0 one clock after last accept", ov);
        end
        tick(1'b0, '0, 1'b1, 1'b0, fi, fo, ov, y);
        checks++;
        if (ov !== 1'b1 || y !== pack_y(180, -96, -204, 80)) begin
            failures++;
            $display("FAIL ramp_result: out_valid=%b y=%h want 1/%h", ov, y, pack_y(180, -96, -204, 80));
        end
        tick(1'b0, '0, 1'b1, 1'b0, fi, fo, ov, y);
        checks++;
        if (ov !== 1'b0) begin
            failures++;
            $display("FAIL ramp_single: out_valid=%b want 0 after consumption", ov);
        end
    endtask

    task automatic test_negative();
        logic ok, all_ok, saw, fi, fo, ov, got;
        logic [YB-1:0] y, seen;
        all_ok = 1'b1; got = 1'b0; seen = '0;
        for (int b = 0; b < NCH; b++) begin
            send_beat({16{16'hFFFF}}, 0, 1'b1, ok, saw);
            all_ok &= ok;
        end
        for (int i = 0; i < 8 && !got; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0, fi, fo, ov, y);
            if (fo) begin got = 1'b1; seen = y; end
        end
        checks++;
        if (!all_ok || !got || seen !== pack_y(-36, 12, 12, -4)) begin
            failures++;
            $display("FAIL negative_result: ok=%b got=%b y=%h want %h", all_ok, got, seen, pack_y(-36, 12, 12, -4));
        end
    endtask

    task automatic test_gaps();
        logic ok, all_ok, saw, any_ov, fi, fo, ov;
        logic [YB-1:0] y;
        all_ok = 1'b1; any_ov = 1'b0;
        for (int b = 0; b < NCH; b++) begin
            send_beat(ramp_tile(1), 3, 1'b1, ok, saw);
            all_ok &= ok; any_ov |= saw;
        end
        checks++;
        if (!all_ok || any_ov) begin
            failures++;
            $display("FAIL gaps_no_early: all_ok=%b early_out_valid=%b, want 1/0", all_ok, any_ov);
        end
        tick(1'b0, '0, 1'b1, 1'b0, fi, fo, ov, y);
        tick(1'b0, '0, 1'b1, 1'b0, fi, fo, ov, y);
        checks++;
        if (ov !== 1'b1 || y !== pack_y(180, -96, -204, 80)) begin
            failures++;
            $display("FAIL gaps_result: out_valid=%b y=%h want 1/%h", ov, y, pack_y(180, -96, -204, 80));
        end
    endtask

    task automatic test_back_to_back();
        logic fi, fo, ov;
        logic [YB-1:0] y;
        logic [YB-1:0] exp_q [3];
        int b, outs, extra;
        b = 0; outs = 0; extra = 0;
        for (int g = 0; g < 3; g++)
            exp_q[g] = pack_y(180 * (g + 1), -96 * (g + 1), -204 * (g + 1), 80 * (g + 1));
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick(b < 12, ramp_tile(b / 4 + 1), 1'b0, 1'b0, fi, fo, ov, y);
            if (fi) b++;
        end
        checks++;
        if (b != 8) begin
            failures++;
            $display("FAIL stall_accepted: got %0d beats want 8 with both stages full", b);
        end
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_ready: in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        end
        for (int cyc = 0; cyc < 200 && outs < 3; cyc++) begin
            tick(b < 12, ramp_tile(b / 4 + 1), 1'b1, 1'b0, fi, fo, ov, y);
            if (fi) b++;
            if (fo) begin
                checks++;
                if (y !== exp_q[outs]) begin
                    failures++;
                    $display("FAIL stall_order[%0d]: got %h want %h", outs, y, exp_q[outs]);
                end
                outs++;
            end
        end
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick(1'b0, '0, 1'b1, 1'b0, fi, fo, ov, y);
            if (fo) extra++;
        end
        checks++;
        if (outs != 3 || extra != 0) begin
            failures++;
            $display("FAIL stall_count: got %0d outputs + %0d extra, want 3 + 0", outs, extra);
        end
    endtask

    task automatic fresh_group(input string tag);
        logic fi, fo, ov;
        logic [YB-1:0] y;
        int b, outs;
        b = 0; outs = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick(b < NCH, ramp_tile(1), 1'b1, 1'b0, fi, fo, ov, y);
            if (fi) b++;
            if (fo) begin
                checks++;
                if (y !== pack_y(180, -96, -204, 80)) begin
                    failures++;
                    $display("FAIL %s_data: got %h want %h", tag, y, pack_y(180, -96, -204, 80));
                end
                outs++;
            end
        end
        checks++;
        if (outs != 1) begin
            failures++;
            $display("FAIL %s_count: got %0d outputs want 1", tag, outs);
        end
    endtask

    task automatic test_clear();
        logic ok, saw, fi, fo, ov;
        logic [YB-1:0] y;
        send_beat(ramp_tile(7), 0, 1'b1, ok, saw);
        send_beat(ramp_tile(7), 0, 1'b1, ok, saw);
        tick(1'b1, ramp_tile(7), 1'b1, 1'b1, fi, fo, ov, y);
        checks++;
        if (fi !== 1'b0) begin
            failures++;
            $display("FAIL clr_blocks_input: accepted=%b want 0 while clr", fi);
        end
        fresh_group("clr");

        send_beat(ramp_tile(7), 0, 1'b1, ok, saw);
        send_beat(ramp_tile(7), 0, 1'b1, ok, saw);
        @(negedge clk);
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_tile !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstn_outputs: out_valid=%b out_tile=%h in_ready=%b want 0/0/1",
                     out_valid, out_tile, in_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        fresh_group("rstn");
    endtask

    task automatic test_random();
        logic [AW-1:0] macc [16];
        logic [YB-1:0] q [$];
        logic [TB-1:0] cur;
        logic [YB-1:0] y, exp_y;
        logic [IW-1:0] e;
        logic fi, fo, ov, v, r;
        longint s [4][4];
        longint yy [2][2];
        int at [2][4];
        int sent, beat, got;
        at = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
        for (int k = 0; k < 16; k++) macc[k] = '0;
        sent = 0; beat = 0; got = 0;
        cur = rand_tile();
        for (int cyc = 0; cyc < 40000 && got < 1000; cyc++) begin
            v = (sent < 1000) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            tick(v, cur, r, 1'b0, fi, fo, ov, y);
            if (fo) begin
                exp_y = (q.size() > 0) ? q.pop_front() : 'x;
                checks++;
                if (y !== exp_y) begin
                    failures++;
                    $display("FAIL random[%0d]: got %h want %h", got, y, exp_y);
                end
                got++;
            end
            if (fi) begin
                for (int k = 0; k < 16; k++) begin
                    e = cur[k*IW +: IW];
                    macc[k] = macc[k] + {{(AW-IW){e[IW-1]}}, e};
                end
                beat++;
                if (beat == NCH) begin
                    for (int rr = 0; rr < 4; rr++)
                        for (int cc = 0; cc < 4; cc++)
                            s[rr][cc] = longint'($signed(macc[4*rr+cc]));
                    for (int i = 0; i < 2; i++)
                        for (int j = 0; j < 2; j++) begin
                            yy[i][j] = 0;
                            for (int rr = 0; rr < 4; rr++)
                                for (int cc = 0; cc < 4; cc++)
                                    yy[i][j] += at[i][rr] * s[rr][cc] * at[j][cc];
                        end
                    q.push_back(pack_y(yy[0][0], yy[0][1], yy[1][0], yy[1][1]));
                    for (int k = 0; k < 16; k++) macc[k] = '0;
                    beat = 0;
                    sent++;
                end
                cur = rand_tile();
            end
        end
        checks++;
        if (got != 1000) begin
            failures++;
            $display("FAIL random_count: got %0d outputs want 1000", got);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_negative();
        test_gaps();
        test_back_to_back();
        test_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
